// File: rtl/ccff_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : ccff_loader_if
//  Description : Bundle of the loader's control, byte-stream, chain and
//                readback signals. The master side is the configuration
//                controller plus the chain; the slave side is the loader.
//  Revision    : 1.0  initial release
// ============================================================================
interface ccff_loader_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              ccff_head;
    logic              ccff_shift_en;
    logic              ccff_tail;
    logic [DATA_W-1:0] rb_data;
    logic              rb_valid;
    logic              busy;
    logic              done;

    modport master (
        output start, cfg_data, cfg_valid, ccff_tail,
        input  cfg_ready, ccff_head, ccff_shift_en, rb_data, rb_valid, busy, done
    );

    modport slave (
        input  start, cfg_data, cfg_valid, ccff_tail,
        output cfg_ready, ccff_head, ccff_shift_en, rb_data, rb_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/ccff_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ccff_loader
//  Description : Serialises configuration bytes (MSB first) into a ccff scan
//                chain of CHAIN_LEN bits while collecting the displaced old
//                chain contents from the tail into readback bytes.
//  Revision    : 1.0  initial release
// ============================================================================
module ccff_loader #(
    parameter int CHAIN_LEN = 29,
    parameter int DATA_W    = 8
) (
    input  wire logic       prog_clk,
    input  wire logic       prog_reset,
    ccff_loader_if.slave    bus
);

    localparam logic [1:0]  C_ST_IDLE   = 2'd0;
    localparam logic [1:0]  C_ST_SHIFT  = 2'd1;
    localparam logic [1:0]  C_ST_DONE   = 2'd2;
    localparam logic [15:0] C_CHAIN_LEN = 16'(CHAIN_LEN);
    localparam logic [3:0]  C_BYTE_BITS = 4'(DATA_W);

    logic [1:0]        state_q,         state_d;
    logic [15:0]       remaining_q,     remaining_d;
    logic [3:0]        word_bits_q,     word_bits_d;
    logic [DATA_W-1:0] word_reg_q,      word_reg_d;
    logic              ccff_head_q,     ccff_head_d;
    logic              ccff_shift_en_q, ccff_shift_en_d;
    logic [DATA_W-1:0] rb_shift_q,      rb_shift_d;
    logic [3:0]        rb_cnt_q,        rb_cnt_d;
    logic [DATA_W-1:0] rb_data_q,       rb_data_d;
    logic              rb_valid_q,      rb_valid_d;

    logic              w_cfg_ready;
    logic              w_accept;
    logic [DATA_W-1:0] w_rb_shift_nxt;
    logic [3:0]        w_rb_cnt_inc;

    // Ready only between bytes while chain bits are still owed; derived from flops only.
    assign w_cfg_ready    = (state_q == C_ST_SHIFT) && (word_bits_q == 4'd0) && (remaining_q != 16'd0);
    assign w_accept       = w_cfg_ready && bus.cfg_valid;
    // Tail bit that arrives while the chain is being clocked this cycle.
    assign w_rb_shift_nxt = {rb_shift_q[DATA_W-2:0], bus.ccff_tail};
    assign w_rb_cnt_inc   = rb_cnt_q + 4'd1;

    // Next-state: byte accept, bit serialisation, readback packing and FSM.
    always_comb begin
        state_d         = state_q;
        remaining_d     = remaining_q;
        word_bits_d     = word_bits_q;
        word_reg_d      = word_reg_q;
        ccff_head_d     = ccff_head_q;
        ccff_shift_en_d = 1'b0;
        rb_shift_d      = rb_shift_q;
        rb_cnt_d        = rb_cnt_q;
        rb_data_d       = rb_data_q;
        rb_valid_d      = 1'b0;

        case (state_q)
            C_ST_IDLE, C_ST_DONE: begin
                if (bus.start) begin
                    state_d     = C_ST_SHIFT;
                    remaining_d = C_CHAIN_LEN;
                    word_bits_d = 4'd0;
                    rb_cnt_d    = 4'd0;
                    rb_shift_d  = '0;
                end
            end

            C_ST_SHIFT: begin
                if (w_accept) begin
                    // The final byte of a load carries only the bits still owed.
                    word_reg_d  = bus.cfg_data;
                    word_bits_d = (remaining_q >= 16'(DATA_W)) ? C_BYTE_BITS : remaining_q[3:0];
                end else if (word_bits_q != 4'd0) begin
                    ccff_head_d     = word_reg_q[DATA_W-1];
                    ccff_shift_en_d = 1'b1;
                    word_reg_d      = {word_reg_q[DATA_W-2:0], 1'b0};
                    word_bits_d     = word_bits_q - 4'd1;
                    remaining_d     = (remaining_q != 16'd0) ? remaining_q - 16'd1 : 16'd0;
                end

                // The chain moves on cycles where the registered enable is high;
                // remaining already hit zero when the last of those was issued.
                if (ccff_shift_en_q) begin
                    rb_shift_d = w_rb_shift_nxt;
                    rb_cnt_d   = w_rb_cnt_inc;
                    if (remaining_q == 16'd0) begin
                        rb_data_d  = w_rb_shift_nxt << (C_BYTE_BITS - w_rb_cnt_inc);
                        rb_valid_d = 1'b1;
                        rb_cnt_d   = 4'd0;
                        state_d    = C_ST_DONE;
                    end else if (w_rb_cnt_inc == C_BYTE_BITS) begin
                        rb_data_d  = w_rb_shift_nxt;
                        rb_valid_d = 1'b1;
                        rb_cnt_d   = 4'd0;
                    end
                end
            end

            default: state_d = C_ST_IDLE;
        endcase
    end

    // State registers; reset overrides start and any byte accept in the same cycle.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q         <= C_ST_IDLE;
            remaining_q     <= 16'd0;
            word_bits_q     <= 4'd0;
            word_reg_q      <= '0;
            ccff_head_q     <= 1'b0;
            ccff_shift_en_q <= 1'b0;
            rb_shift_q      <= '0;
            rb_cnt_q        <= 4'd0;
            rb_data_q       <= '0;
            rb_valid_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            remaining_q     <= remaining_d;
            word_bits_q     <= word_bits_d;
            word_reg_q      <= word_reg_d;
            ccff_head_q     <= ccff_head_d;
            ccff_shift_en_q <= ccff_shift_en_d;
            rb_shift_q      <= rb_shift_d;
            rb_cnt_q        <= rb_cnt_d;
            rb_data_q       <= rb_data_d;
            rb_valid_q      <= rb_valid_d;
        end
    end

    assign bus.cfg_ready     = w_cfg_ready;
    assign bus.ccff_head     = ccff_head_q;
    assign bus.ccff_shift_en = ccff_shift_en_q;
    assign bus.rb_data       = rb_data_q;
    assign bus.rb_valid      = rb_valid_q;
    assign bus.busy          = (state_q == C_ST_SHIFT);
    assign bus.done          = (state_q == C_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ccff_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ccff_loader
//  Description : Scoreboard bench for ccff_loader: a 29-bit and an 8-bit
//                chain model, directed loads, gaps, restarts and mid-load reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ccff_loader;

    logic prog_clk = 1'b0;
    logic prog_reset;

    always #5 prog_clk = ~prog_clk;

    ccff_loader_if bus  ();
    ccff_loader_if bus8 ();

    ccff_loader #(.CHAIN_LEN(29)) dut (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .bus        (bus)
    );

    ccff_loader #(.CHAIN_LEN(8)) dut8 (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .bus        (bus8)
    );

    // Chain models: head enters bit 0, tail leaves from the top bit.
    logic [28:0] chain;
    logic        preload;
    logic [28:0] preload_val;
    logic [7:0]  chain8;
    logic        preload8;
    logic [7:0]  preload8_val;

    always @(posedge prog_clk) begin
        if (preload)                chain <= preload_val;
        else if (bus.ccff_shift_en) chain <= {chain[27:0], bus.ccff_head};
        if (preload8)                chain8 <= preload8_val;
        else if (bus8.ccff_shift_en) chain8 <= {chain8[6:0], bus8.ccff_head};
    end

    assign bus.ccff_tail  = chain[28];
    assign bus8.ccff_tail = chain8[7];

    int cyc = 0;
    always @(posedge prog_clk) cyc <= cyc + 1;

    logic       exp_head[$];
    logic [7:0] exp_rb[$];
    int checks    = 0;
    int errors    = 0;
    int shift_cnt = 0;
    int done_cyc  = 0;
    int start_cyc = 0;
    logic done_prev = 1'b0;

    // 29 loaded bits, first-shifted bit in the MSB
    localparam logic [31:0] PAT_WORD = 32'hA53CFF81;
    logic [28:0] pat29;
    assign pat29 = PAT_WORD[31:3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge prog_clk);
        #1;
    endtask

    // Monitor: pops expected head bits and readback bytes when the DUT presents them.
    always @(negedge prog_clk) begin
        if (bus.ccff_shift_en) begin
            shift_cnt++;
            if (exp_head.size() == 0) begin
                checks++; errors++;
                $display("FAIL head_unexpected: got %0b with no bit expected", bus.ccff_head);
            end else begin
                chk("ccff_head", 32'(bus.ccff_head), 32'(exp_head.pop_front()));
            end
        end
        if (bus.rb_valid) begin
            if (exp_rb.size() == 0) begin
                checks++; errors++;
                $display("FAIL rb_unexpected: got %0h with no byte expected", bus.rb_data);
            end else begin
                chk("rb_data", 32'(bus.rb_data), 32'(exp_rb.pop_front()));
            end
        end
        if (bus.done && !done_prev) done_cyc = cyc;
        done_prev = bus.done;
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_head"},     32'(bus.ccff_head),     32'd0);
        chk({tag, "_shift_en"}, 32'(bus.ccff_shift_en), 32'd0);
        chk({tag, "_cfg_ready"},32'(bus.cfg_ready),     32'd0);
        chk({tag, "_rb_data"},  32'(bus.rb_data),       32'd0);
        chk({tag, "_rb_valid"}, 32'(bus.rb_valid),      32'd0);
        chk({tag, "_busy"},     32'(bus.busy),          32'd0);
        chk({tag, "_done"},     32'(bus.done),          32'd0);
    endtask

    // Offer one byte: wait for ready, optionally idle for gap cycles, then present it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        while (!bus.cfg_ready && t < 40) begin
            tick();
            t++;
        end
        if (!bus.cfg_ready) begin
            chk("cfg_ready_timeout", 32'(bus.cfg_ready), 32'd1);
            return;
        end
        for (int g = 0; g < gap; g++) begin
            tick();
            chk("gap_ready_high", 32'(bus.cfg_ready), 32'd1);
            chk("gap_shift_en_low", 32'(bus.ccff_shift_en), 32'd0);
        end
        bus.cfg_data  = b;
        bus.cfg_valid = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = 8'($urandom);
    endtask

    // Full 29-bit load of A5,3C,FF,81 with hand-computed readback bytes.
    task automatic do_load(input int gap, input bit mid_start,
                           input logic [7:0] r0, input logic [7:0] r1,
                           input logic [7:0] r2, input logic [7:0] r3,
                           input bit chk_lat);
        logic [7:0] bytes [4];
        int t;
        bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF; bytes[3] = 8'h81;
        for (int i = 0; i < 29; i++) exp_head.push_back(PAT_WORD[31-i]);
        exp_rb.push_back(r0); exp_rb.push_back(r1);
        exp_rb.push_back(r2); exp_rb.push_back(r3);
        shift_cnt = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        start_cyc = cyc;
        chk("start_busy", 32'(bus.busy), 32'd1);
        chk("start_done_low", 32'(bus.done), 32'd0);
        for (int k = 0; k < 4; k++) begin
            send_byte(bytes[k], (k == 0) ? 0 : gap);
            if (k == 0 && mid_start) begin
                bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
                chk("mid_start_busy", 32'(bus.busy), 32'd1);
            end
        end
        t = 0;
        while (!bus.done && t < 60) begin
            tick();
            t++;
        end
        chk("load_done", 32'(bus.done), 32'd1);
        chk("shift_en_cycles", 32'(shift_cnt), 32'd29);
        if (chk_lat) chk("done_latency", 32'(done_cyc - start_cyc), 32'd34);
        chk("head_queue_left", 32'(exp_head.size()), 32'd0);
        chk("rb_queue_left", 32'(exp_rb.size()), 32'd0);
        chk("busy_in_done", 32'(bus.busy), 32'd0);
        chk("chain_contents", 32'(chain), 32'(pat29));
    endtask

    initial begin
        int t;
        int sh8, rdy8, rbv8, lat8;
        logic [7:0] head8, rbl8;

        prog_reset    = 1'b1;
        bus.start     = 1'b0; bus.cfg_valid  = 1'b0; bus.cfg_data  = 8'h00;
        bus8.start    = 1'b0; bus8.cfg_valid = 1'b0; bus8.cfg_data = 8'h00;
        preload       = 1'b1; preload_val  = '1;
        preload8      = 1'b1; preload8_val = 8'h5A;
        repeat (3) tick();
        preload  = 1'b0;
        preload8 = 1'b0;
        check_reset_vals("reset");
        prog_reset = 1'b0;
        tick();
        chk("idle_ready", 32'(bus.cfg_ready), 32'd0);
        chk("idle_busy",  32'(bus.busy),      32'd0);

        // Chain of ones, back-to-back bytes
        do_load(0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hF8, 1'b1);

        // Restart from DONE with 5-cycle gaps and an ignored start mid-load
        do_load(5, 1'b1, 8'hA5, 8'h3C, 8'hFF, 8'h80, 1'b0);

        // Reset after 12 shifted bits
        preload = 1'b1; preload_val = '1;
        tick();
        preload = 1'b0;
        shift_cnt = 0;
        for (int i = 0; i < 12; i++) exp_head.push_back(PAT_WORD[31-i]);
        exp_rb.push_back(8'hFF);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        t = 0;
        while (shift_cnt < 12 && t < 40) begin
            tick();
            t++;
        end
        chk("shift_cnt_at_reset", 32'(shift_cnt), 32'd12);
        prog_reset = 1'b1;
        tick();
        check_reset_vals("midrst");
        prog_reset = 1'b0;
        chk("midrst_head_queue", 32'(exp_head.size()), 32'd0);
        chk("midrst_rb_queue", 32'(exp_rb.size()), 32'd0);
        tick();
        chk("midrst_still_idle", 32'(bus.busy), 32'd0);

        // Reload: 17 old ones followed by the 12 bits left by the aborted load
        do_load(0, 1'b0, 8'hFF, 8'hFF, 8'hD2, 8'h98, 1'b1);

        // 8-bit chain: one byte, one readback, done ten edges after start
        sh8 = 0; rdy8 = 0; rbv8 = 0; head8 = 8'h00; rbl8 = 8'h00;
        bus8.cfg_data  = 8'hC3;
        bus8.cfg_valid = 1'b1;
        bus8.start     = 1'b1;
        tick();
        bus8.start = 1'b0;
        for (lat8 = 0; lat8 < 40; lat8++) begin
            if (bus8.ccff_shift_en) begin
                head8 = {head8[6:0], bus8.ccff_head};
                sh8++;
            end
            if (bus8.cfg_ready) rdy8++;
            if (bus8.rb_valid) begin
                rbv8++;
                rbl8 = bus8.rb_data;
            end
            if (bus8.done) break;
            tick();
        end
        bus8.cfg_valid = 1'b0;
        chk("cl8_ready_cycles", 32'(rdy8),   32'd1);
        chk("cl8_shift_cycles", 32'(sh8),    32'd8);
        chk("cl8_head_bits",    32'(head8),  32'hC3);
        chk("cl8_rb_pulses",    32'(rbv8),   32'd1);
        chk("cl8_rb_data",      32'(rbl8),   32'h5A);
        chk("cl8_done_latency", 32'(lat8),   32'd10);
        chk("cl8_chain",        32'(chain8), 32'hC3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
